// File: rtl/ysyx_22041461_pipe_skid_reg_if.sv
// Valid/ready payload channel between two adjacent pipeline stages.
// A beat transfers on a posedge where valid & ready are both 1; the master keeps
// valid and data steady until that transfer, and ready may not depend on the
// master's valid.
interface ysyx_22041461_pipe_skid_reg_if #(
    parameter int unsigned DATA_W = 96
);
    logic              valid;
    logic              ready;
    logic [DATA_W-1:0] data;

    modport master (output valid, output data, input ready);
    modport slave  (input valid, input data, output ready);
endinterface

// File: rtl/ysyx_22041461_pipe_skid_reg.sv
// Pipeline-stage register with flush and an optional 2-entry skid buffer.
// Main entry drives the downstream side; the skid entry catches one beat under stall.
module ysyx_22041461_pipe_skid_reg #(
    parameter int unsigned       DATA_W    = 96,
    parameter logic [DATA_W-1:0] RESET_VAL = DATA_W'(96'h0000_0000_0000_0000_8000_0000),
    parameter bit                SKID      = 1'b1
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          flush,
    ysyx_22041461_pipe_skid_reg_if.slave  in_if,
    ysyx_22041461_pipe_skid_reg_if.master out_if,
    output logic [1:0]                    count,
    output logic [1:0]                    state_dbg
);

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_FULL  = 2'd1,
        ST_SKID  = 2'd2
    } state_e;

    state_e            state_q;
    state_e            state_d;
    logic [DATA_W-1:0] main_q;
    logic [DATA_W-1:0] skid_q;
    logic              in_ready_q;
    logic              in_ready;
    logic              out_valid;
    logic              in_xfer;
    logic              load_main_in;
    logic              load_main_skid;
    logic              load_skid;

    // With the skid buffer, upstream ready comes straight from a flop.
    assign in_ready = SKID ? in_ready_q : ((state_q == ST_EMPTY) | out_if.ready);
    assign in_xfer  = in_if.valid & in_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_EMPTY;
            in_ready_q <= 1'b1;
        end else begin
            state_q    <= state_d;
            in_ready_q <= (state_d != ST_SKID);
        end
    end

    always_comb begin
        state_d        = state_q;
        load_main_in   = 1'b0;
        load_main_skid = 1'b0;
        load_skid      = 1'b0;
        if (flush) begin
            state_d = ST_EMPTY;
        end else begin
            case (state_q)
                ST_EMPTY: begin
                    if (in_xfer) begin
                        state_d      = ST_FULL;
                        load_main_in = 1'b1;
                    end
                end
                ST_FULL: begin
                    if (in_xfer && out_if.ready) begin
                        load_main_in = 1'b1;
                    end else if (in_xfer && SKID) begin
                        state_d   = ST_SKID;
                        load_skid = 1'b1;
                    end else if (!in_if.valid && out_if.ready) begin
                        state_d = ST_EMPTY;
                    end
                end
                ST_SKID: begin
                    if (out_if.ready) begin
                        state_d        = ST_FULL;
                        load_main_skid = 1'b1;
                    end
                end
                default: state_d = ST_EMPTY;
            endcase
        end
    end

    always_comb begin
        out_valid = 1'b0;
        count     = 2'd0;
        case (state_q)
            ST_FULL: begin
                out_valid = 1'b1;
                count     = 2'd1;
            end
            ST_SKID: begin
                out_valid = 1'b1;
                count     = 2'd2;
            end
            default: begin
                out_valid = 1'b0;
                count     = 2'd0;
            end
        endcase
    end

    // Payload registers are left untouched by flush; they are don't-care while invalid.
    always_ff @(posedge clk) begin
        if (rst) begin
            main_q <= RESET_VAL;
            skid_q <= '0;
        end else begin
            if (load_main_in) begin
                main_q <= in_if.data;
            end else if (load_main_skid) begin
                main_q <= skid_q;
            end
            if (load_skid) begin
                skid_q <= in_if.data;
            end
        end
    end

    assign in_if.ready  = in_ready;
    assign out_if.valid = out_valid;
    assign out_if.data  = main_q;
    assign state_dbg    = state_q;

endmodule

// File: tb/tb_ysyx_22041461_pipe_skid_reg.sv
// Drives four stage registers (96/40-bit x SKID 1/0) with shared stimulus and checks
// each against a queue-based model of a FIFO with capacity 2 (skid) or 1 (no skid).
module tb_ysyx_22041461_pipe_skid_reg;

    localparam int NDUT = 4;
    localparam logic [95:0] MASK40 = {56'h0, 40'hFF_FFFF_FFFF};
    localparam logic [95:0] RST_EXP = 96'h0000_0000_0000_0000_8000_0000;

    logic        clk;
    logic        rst;
    logic        flush;
    logic        in_valid;
    logic        out_ready;
    logic [95:0] in_data;

    logic [NDUT-1:0]       rdy;
    logic [NDUT-1:0]       vld;
    logic [NDUT-1:0][95:0] dat;
    logic [NDUT-1:0][1:0]  cnt;
    logic [NDUT-1:0][1:0]  st;

    logic [95:0] exp_q [NDUT][$];
    int n_checks = 0;
    int n_pass   = 0;

    // g=0: 96b skid, g=1: 96b plain, g=2: 40b skid, g=3: 40b plain
    for (genvar g = 0; g < NDUT; g++) begin : g_dut
        localparam int W = (g < 2) ? 96 : 40;
        localparam bit S = ((g % 2) == 0);
        localparam logic [W-1:0] RV = W'(96'h0000_0000_0000_0000_8000_0000);

        ysyx_22041461_pipe_skid_reg_if #(.DATA_W(W)) up_if ();
        ysyx_22041461_pipe_skid_reg_if #(.DATA_W(W)) dn_if ();

        assign up_if.valid = in_valid;
        assign up_if.data  = in_data[W-1:0];
        assign dn_if.ready = out_ready;
        assign rdy[g]      = up_if.ready;
        assign vld[g]      = dn_if.valid;
        assign dat[g]      = 96'(dn_if.data);

        ysyx_22041461_pipe_skid_reg #(
            .DATA_W   (W),
            .RESET_VAL(RV),
            .SKID     (S)
        ) u_dut (
            .clk      (clk),
            .rst      (rst),
            .flush    (flush),
            .in_if    (up_if),
            .out_if   (dn_if),
            .count    (cnt[g]),
            .state_dbg(st[g])
        );
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic bit is_skid(input int g);
        return (g % 2) == 0;
    endfunction

    function automatic logic [95:0] msk(input logic [95:0] d, input int g);
        return (g >= 2) ? (d & MASK40) : d;
    endfunction

    function automatic bit exp_ready(input int g);
        if (is_skid(g)) return exp_q[g].size() < 2;
        return (exp_q[g].size() == 0) || out_ready;
    endfunction

    function automatic logic [95:0] rnd96();
        return {$urandom, $urandom, $urandom};
    endfunction

    // One clock edge: decide transfers from the model, then apply them after the edge.
    task automatic tick();
        bit          in_x  [NDUT];
        bit          out_x [NDUT];
        logic        r;
        logic        f;
        logic [95:0] d;
        r = rst;
        f = flush;
        d = in_data;
        for (int g = 0; g < NDUT; g++) begin
            out_x[g] = (exp_q[g].size() > 0) && out_ready;
            in_x[g]  = in_valid && exp_ready(g);
        end
        @(posedge clk);
        #1;
        for (int g = 0; g < NDUT; g++) begin
            if (r || f) begin
                exp_q[g].delete();
            end else begin
                if (out_x[g]) void'(exp_q[g].pop_front());
                if (in_x[g]) exp_q[g].push_back(msk(d, g));
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; flush = 1'b0; in_valid = 1'b1; out_ready = 1'b0; in_data = rnd96();
        tick();
        tick();
        rst = 1'b0; in_valid = 1'b0;
        #1;
        for (int g = 0; g < NDUT; g++) begin
            n_checks++; if (vld[g] !== 1'b0) $display("FAIL reset_valid dut%0d: got %b want 0", g, vld[g]); else n_pass++;
            n_checks++; if (dat[g] !== RST_EXP) $display("FAIL reset_data dut%0d: got %h want %h", g, dat[g], RST_EXP); else n_pass++;
            n_checks++; if (cnt[g] !== 2'd0) $display("FAIL reset_count dut%0d: got %0d want 0", g, cnt[g]); else n_pass++;
            n_checks++; if (rdy[g] !== 1'b1) $display("FAIL reset_ready dut%0d: got %b want 1", g, rdy[g]); else n_pass++;
        end
        tick();
        for (int g = 0; g < NDUT; g++) begin
            n_checks++; if (vld[g] !== 1'b0) $display("FAIL reset_nocapture dut%0d: got %b want 0", g, vld[g]); else n_pass++;
        end
    endtask

    task automatic test_stream();
        out_ready = 1'b1;
        for (int i = 1; i <= 20; i++) begin
            in_valid = 1'b1;
            in_data  = 96'(i);
            #1;
            for (int g = 0; g < NDUT; g++) begin
                n_checks++; if (rdy[g] !== 1'b1) $display("FAIL stream_ready dut%0d beat %0d: got %b want 1", g, i, rdy[g]); else n_pass++;
            end
            tick();
            for (int g = 0; g < NDUT; g++) begin
                n_checks++; if (vld[g] !== 1'b1) $display("FAIL stream_valid dut%0d beat %0d: got %b want 1", g, i, vld[g]); else n_pass++;
                n_checks++; if (dat[g] !== 96'(i)) $display("FAIL stream_data dut%0d: got %h want %h", g, dat[g], 96'(i)); else n_pass++;
                n_checks++; if (cnt[g] !== 2'd1) $display("FAIL stream_count dut%0d beat %0d: got %0d want 1", g, i, cnt[g]); else n_pass++;
            end
        end
        in_valid = 1'b0;
        tick();
        for (int g = 0; g < NDUT; g++) begin
            n_checks++; if (vld[g] !== 1'b0) $display("FAIL stream_drain dut%0d: got %b want 0", g, vld[g]); else n_pass++;
        end
    endtask

    task automatic test_backpressure();
        logic [95:0] a, b, c;
        a = rnd96(); b = rnd96(); c = rnd96();
        out_ready = 1'b0; in_valid = 1'b1; in_data = a;
        #1; tick();
        in_data = b;
        #1; tick();
        in_data = c;
        for (int k = 0; k < 3; k++) begin
            #1;
            for (int g = 0; g < NDUT; g += 2) begin
                n_checks++; if (rdy[g] !== 1'b0) $display("FAIL bp_stall_ready dut%0d: got %b want 0", g, rdy[g]); else n_pass++;
                n_checks++; if (cnt[g] !== 2'd2) $display("FAIL bp_stall_count dut%0d: got %0d want 2", g, cnt[g]); else n_pass++;
                n_checks++; if (dat[g] !== msk(a, g)) $display("FAIL bp_stall_data dut%0d: got %h want %h", g, dat[g], msk(a, g)); else n_pass++;
            end
            tick();
        end
        out_ready = 1'b1;
        #1;
        tick();
        for (int g = 0; g < NDUT; g += 2) begin
            n_checks++; if (dat[g] !== msk(b, g)) $display("FAIL bp_release_data dut%0d: got %h want %h", g, dat[g], msk(b, g)); else n_pass++;
            n_checks++; if (cnt[g] !== 2'd1) $display("FAIL bp_release_count dut%0d: got %0d want 1", g, cnt[g]); else n_pass++;
            n_checks++; if (rdy[g] !== 1'b1) $display("FAIL bp_release_ready dut%0d: got %b want 1", g, rdy[g]); else n_pass++;
        end
        tick();
        for (int g = 0; g < NDUT; g += 2) begin
            n_checks++; if (dat[g] !== msk(c, g)) $display("FAIL bp_late_data dut%0d: got %h want %h", g, dat[g], msk(c, g)); else n_pass++;
            n_checks++; if (vld[g] !== 1'b1) $display("FAIL bp_late_valid dut%0d: got %b want 1", g, vld[g]); else n_pass++;
        end
        in_valid = 1'b0;
        tick();
        for (int g = 0; g < NDUT; g += 2) begin
            n_checks++; if (vld[g] !== 1'b0) $display("FAIL bp_drain dut%0d: got %b want 0", g, vld[g]); else n_pass++;
        end
    endtask

    task automatic test_flush();
        logic [95:0] d, e;
        d = rnd96(); e = rnd96();
        out_ready = 1'b0; in_valid = 1'b1; in_data = rnd96();
        #1; tick();
        in_data = rnd96();
        #1; tick();
        for (int g = 0; g < NDUT; g += 2) begin
            n_checks++; if (cnt[g] !== 2'd2) $display("FAIL flush_setup_count dut%0d: got %0d want 2", g, cnt[g]); else n_pass++;
        end
        flush = 1'b1; in_data = d;
        #1; tick();
        flush = 1'b0; in_valid = 1'b0;
        #1;
        for (int g = 0; g < NDUT; g++) begin
            n_checks++; if (vld[g] !== 1'b0) $display("FAIL flush_valid dut%0d: got %b want 0", g, vld[g]); else n_pass++;
            n_checks++; if (cnt[g] !== 2'd0) $display("FAIL flush_count dut%0d: got %0d want 0", g, cnt[g]); else n_pass++;
            n_checks++; if (rdy[g] !== 1'b1) $display("FAIL flush_ready dut%0d: got %b want 1", g, rdy[g]); else n_pass++;
        end
        out_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            for (int g = 0; g < NDUT; g++) begin
                n_checks++; if (vld[g] !== 1'b0) $display("FAIL flush_dropped dut%0d: got %b want 0", g, vld[g]); else n_pass++;
            end
        end
        in_valid = 1'b1; in_data = e;
        #1; tick();
        for (int g = 0; g < NDUT; g++) begin
            n_checks++; if (dat[g] !== msk(e, g) || vld[g] !== 1'b1) $display("FAIL flush_refill dut%0d: got %b/%h want 1/%h", g, vld[g], dat[g], msk(e, g)); else n_pass++;
        end
        in_valid = 1'b0;
        tick();
    endtask

    task automatic test_simultaneous();
        logic [95:0] f, h;
        f = rnd96(); h = rnd96();
        out_ready = 1'b0; in_valid = 1'b1; in_data = f;
        #1; tick();
        in_valid = 1'b0;
        rst = 1'b1; flush = 1'b1;
        #1; tick();
        rst = 1'b0; flush = 1'b0;
        #1;
        for (int g = 0; g < NDUT; g++) begin
            n_checks++; if (vld[g] !== 1'b0) $display("FAIL simul_rst_valid dut%0d: got %b want 0", g, vld[g]); else n_pass++;
            n_checks++; if (dat[g] !== RST_EXP) $display("FAIL simul_rst_data dut%0d: got %h want %h", g, dat[g], RST_EXP); else n_pass++;
            n_checks++; if (cnt[g] !== 2'd0) $display("FAIL simul_rst_count dut%0d: got %0d want 0", g, cnt[g]); else n_pass++;
        end
        in_valid = 1'b1; in_data = f;
        #1; tick();
        in_data = h; out_ready = 1'b1;
        #1;
        for (int g = 0; g < NDUT; g++) begin
            n_checks++; if (rdy[g] !== 1'b1) $display("FAIL simul_xfer_ready dut%0d: got %b want 1", g, rdy[g]); else n_pass++;
        end
        tick();
        for (int g = 0; g < NDUT; g++) begin
            n_checks++; if (cnt[g] !== 2'd1) $display("FAIL simul_xfer_count dut%0d: got %0d want 1", g, cnt[g]); else n_pass++;
            n_checks++; if (dat[g] !== msk(h, g)) $display("FAIL simul_xfer_data dut%0d: got %h want %h", g, dat[g], msk(h, g)); else n_pass++;
        end
        in_valid = 1'b0;
        tick();
    endtask

    task automatic test_random();
        for (int cyc = 0; cyc < 3000; cyc++) begin
            flush     = ($urandom_range(0, 9) == 0);
            in_valid  = $urandom_range(0, 1) == 1;
            out_ready = $urandom_range(0, 3) != 0;
            in_data   = rnd96();
            #1;
            for (int g = 0; g < NDUT; g++) begin
                n_checks++; if (rdy[g] !== exp_ready(g)) $display("FAIL rnd_ready dut%0d cyc %0d: got %b want %b", g, cyc, rdy[g], exp_ready(g)); else n_pass++;
                n_checks++; if (vld[g] !== (exp_q[g].size() > 0)) $display("FAIL rnd_valid dut%0d cyc %0d: got %b want %0d", g, cyc, vld[g], exp_q[g].size() > 0); else n_pass++;
                n_checks++; if (cnt[g] !== 2'(exp_q[g].size())) $display("FAIL rnd_count dut%0d cyc %0d: got %0d want %0d", g, cyc, cnt[g], exp_q[g].size()); else n_pass++;
                if (exp_q[g].size() > 0) begin
                    n_checks++; if (dat[g] !== exp_q[g][0]) $display("FAIL rnd_data dut%0d cyc %0d: got %h want %h", g, cyc, dat[g], exp_q[g][0]); else n_pass++;
                end
            end
            tick();
        end
        flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        tick(); tick(); tick();
        for (int g = 0; g < NDUT; g++) begin
            n_checks++; if (vld[g] !== 1'b0 || exp_q[g].size() != 0) $display("FAIL rnd_final_empty dut%0d: got %b want 0", g, vld[g]); else n_pass++;
        end
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_data = '0;
        test_reset();
        test_stream();
        test_backpressure();
        test_flush();
        test_simultaneous();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
